// File: rtl/stream_arbiter_rr.sv
// Round-robin N:1 valid/ready stream arbiter with zero-latency combinational data path.
// Backpressure on the output locks the current grant until it completes, so payloads never switch mid-transfer.
module stream_arbiter_rr #(
  parameter int N_INP      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
  input  logic [N_INP-1:0]            inp_valid_i,
  output logic [N_INP-1:0]            inp_ready_o,
  output logic [DATA_WIDTH-1:0]       oup_data_o,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [IDX_WIDTH-1:0]        oup_idx_o
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               lock_q;
  logic [IDX_WIDTH-1:0] rr_q;
  logic [IDX_WIDTH-1:0] lock_idx_q;
  logic [IDX_WIDTH-1:0] grant;
  logic [IDX_WIDTH-1:0] rr_next;
  logic                 found;
  logic                 handshake;
  logic                 lock_drop;

  // Rotating-priority scan starting at rr_q; a held lock bypasses the scan entirely.
  always_comb begin : grant_sel
    int j;
    j     = 0;
    found = 1'b0;
    grant = '0;
    if (lock_q == LOCKED) begin
      grant = lock_idx_q;
      found = 1'b1;
    end else begin
      for (int k = 0; k < N_INP; k++) begin
        j = int'(rr_q) + k;
        if (j >= N_INP) j = j - N_INP;
        if (!found && inp_valid_i[j]) begin
          found = 1'b1;
          grant = IDX_WIDTH'(j);
        end
      end
    end
  end

  assign oup_valid_o = inp_valid_i[grant];
  assign oup_data_o  = inp_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign oup_idx_o   = grant;
  assign handshake   = oup_valid_o & oup_ready_i;
  assign rr_next     = (grant == IDX_WIDTH'(N_INP - 1)) ? '0 : grant + 1'b1;

  // A locked source that withdraws valid is a protocol violation; the lock is simply released.
  assign lock_drop   = (lock_q == LOCKED) & ~inp_valid_i[lock_idx_q];

  always_comb begin
    inp_ready_o        = '0;
    inp_ready_o[grant] = oup_ready_i & oup_valid_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= ARB;
      lock_idx_q <= '0;
    end else if (handshake) begin
      rr_q   <= rr_next;
      lock_q <= ARB;
    end else if (lock_q == LOCKED) begin
      if (lock_drop) lock_q <= ARB;
    end else if (oup_valid_o) begin
      lock_q     <= LOCKED;
      lock_idx_q <= grant;
    end
  end

endmodule

// File: doc/stream_arbiter_rr.md
STREAM_ARBITER_RR -- requirements
Module: stream_arbiter_rr

Interface
REQ-001 Parameter N_INP, default 4: number of input streams, legal range 1..64.
REQ-002 Parameter DATA_WIDTH, default 32: payload width per stream.
REQ-003 Parameter IDX_WIDTH, default max(1, clog2(N_INP)): dependent, never overridden.
REQ-004 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_i  input  1  reset, synchronous, active-high.
REQ-006 Port inp_data_i  input  N_INP*DATA_WIDTH  payloads; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Port inp_valid_i  input  N_INP  per-input valid.
REQ-008 Port inp_ready_o  output  N_INP  per-input ready.
REQ-009 Port oup_data_o  output  DATA_WIDTH  payload of granted input.
REQ-010 Port oup_valid_o  output  1  output valid.
REQ-011 Port oup_ready_i  input  1  output ready.
REQ-012 Port oup_idx_o  output  IDX_WIDTH  index of granted input, valid whenever oup_valid_o=1.

Function
REQ-013 Handshake on any port: valid&ready high in the same cycle; zero-latency combinational path input to output, no buffering.
REQ-014 State: priority pointer rr_q (IDX_WIDTH, range 0..N_INP-1), lock flag lock_q, locked index lock_idx_q.
REQ-015 Two states: ARB (lock_q=0) and LOCKED (lock_q=1).
REQ-016 ARB: grant = first i with inp_valid_i[i]=1, scanning rr_q, rr_q+1, ..., wrapping past N_INP-1 to 0.
REQ-017 LOCKED: grant = lock_idx_q regardless of other valids.
REQ-018 oup_valid_o = inp_valid_i[grant] (0 in ARB when no input valid); oup_data_o and oup_idx_o driven from grant.
REQ-019 inp_ready_o[grant] = oup_ready_i when a grant exists; all other inp_ready_o bits 0; all 0 when no input valid.
REQ-020 ARB -> LOCKED when oup_valid_o=1 and oup_ready_i=0; lock_idx_q <= grant.
REQ-021 LOCKED -> ARB on output handshake, or when inp_valid_i[lock_idx_q]=0 (protocol violation; simulation assertion fires).
REQ-022 On every output handshake rr_q <= grant+1, wrapping N_INP-1 -> 0; rr_q unchanged otherwise.
REQ-023 Handshake in the same cycle as a lock request: handshake wins, state stays/returns ARB.
REQ-024 Fairness: any continuously valid input granted within N_INP output handshakes.
REQ-025 N_INP=1: pure pass-through, oup_idx_o=0 constant, rr_q held 0.
REQ-026 oup_data_o stable while oup_valid_o=1 and oup_ready_i=0, provided the granted input keeps its data stable.

Reset
REQ-027 rst_i=1 at a rising edge: rr_q=0, lock_q=0, lock_idx_q=0; takes effect next cycle, overriding any concurrent handshake update.
REQ-028 Outputs are combinational from state and inputs; during/after reset with all inp_valid_i=0: oup_valid_o=0, inp_ready_o=0, oup_idx_o=0.
REQ-029 Reset mid-transfer drops any lock; the transfer in flight is not retained.

Verification (N_INP=4, DATA_WIDTH=8)
REQ-030 After reset, inp_valid_i=4'b1111, oup_ready_i=1 for 8 cycles, data i=8'hA0+i -> oup_idx_o sequence 0,1,2,3,0,1,2,3, matching data.
REQ-031 rr_q=0, inp_valid_i=4'b0110, oup_ready_i=0 for 3 cycles then 1; input 1 deasserts valid after its handshake -> idx 1 held 4 cycles with inp_ready_o=4'b0000 for 3, 4'b0010 on cycle 4; next grant idx 2.
REQ-032 Locked on idx 2 with oup_ready_i=0; raise inp_valid_i[0] -> grant stays 2, oup_data_o unchanged until handshake.
REQ-033 Locked on idx 3, inp_valid_i[3] drops -> state ARB next cycle, assertion fires, rr_q unchanged.
REQ-034 Locked on idx 1, rst_i=1 for one cycle -> lock_q=0, rr_q=0; with inp_valid_i=4'b0011 next grant idx 0.
REQ-035 N_INP=1, random valid/ready/data for 1000 cycles -> outputs equal inputs every cycle, oup_idx_o=0.
